dsi_pkt_builder: RTL and testbench

Packet assembler for the MIPI DSI LCM-init path. It accepts one command descriptor at a time (VC, data type, word count or two short-packet parameters) and, for long packets, a byte stream of payload. It emits the complete DSI packet as a byte stream: header, ECC, payload and CRC-16 checksum. It sits directly upstream of the `ecc` header-ECC stage, drives that stage's request port, and consumes its 8-bit result to fill header byte 3.

---
 rtl/dsi_pkg.sv | 31 +++
 rtl/dsi_crc16.sv | 36 +++
 rtl/dsi_pkt_builder.sv | 156 +++++++++++++++
 tb/tb_dsi_pkt_builder.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsi_pkg.sv
// Shared definitions for the DSI packet builder: FSM states, CRC constants,
// common data types and the byte-wide reflected CRC-16 step.
package dsi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ECC_REQ,
    ST_ECC_WAIT,
    ST_HDR,
    ST_PLD,
    ST_CRC
  } state_t;

  localparam logic [15:0] CRC_INIT      = 16'hFFFF;
  localparam logic [15:0] CRC_POLY_REFL = 16'h8408;

  localparam logic [5:0] DCS_SHORT_W0 = 6'h05;
  localparam logic [5:0] DCS_SHORT_W1 = 6'h15;
  localparam logic [5:0] DCS_LONG_W   = 6'h39;

  // Folds one byte into the CRC, LSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/dsi_crc16.sv
// Running CRC-16-CCITT (reflected) over a byte stream.
// init reloads the seed and wins over en in the same cycle.
module dsi_crc16
  import dsi_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  din,
  output logic [15:0] crc
);

  logic [15:0] crc_reg;
  logic [15:0] crc_next;

  always_comb begin
    crc_next = crc_reg;
    if (init) begin
      crc_next = CRC_INIT;
    end else if (en) begin
      crc_next = crc16_byte(crc_reg, din);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      crc_reg <= CRC_INIT;
    end else begin
      crc_reg <= crc_next;
    end
  end

  assign crc = crc_reg;

endmodule

// File: rtl/dsi_pkt_builder.sv
// DSI packet assembler: latches a descriptor, asks the external ECC stage for
// the header ECC, then streams header, optional payload and CRC-16 bytes.
module dsi_pkt_builder
  import dsi_pkg::*;
#(
  parameter int unsigned WC_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_long,
  input  logic [1:0]  cmd_vc,
  input  logic [5:0]  cmd_dt,
  input  logic [15:0] cmd_wc,
  input  logic        pld_valid,
  output logic        pld_ready,
  input  logic [7:0]  pld_data,
  output logic        ecc_en,
  output logic [23:0] ecc_data,
  input  logic [7:0]  ecc_code,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_last
);

  state_t            state_reg;
  state_t            state_next;
  logic              long_reg;
  logic [7:0]        di_reg;
  logic [15:0]       wc_reg;
  logic [WC_W-1:0]   cnt_reg;
  logic [1:0]        idx_reg;
  logic [7:0]        ecc_q_reg;
  logic [7:0]        hdr_byte;
  logic [15:0]       crc_val;
  logic              accept;
  logic              tx_fire;
  logic              crc_en;

  // Held low during reset so a descriptor offered then is never taken.
  assign cmd_ready = (state_reg == ST_IDLE) && !rst;
  assign accept    = cmd_valid && cmd_ready;
  assign tx_fire   = tx_valid && tx_ready;
  assign crc_en    = (state_reg == ST_PLD) && pld_valid && tx_ready;

  always_comb begin
    hdr_byte = di_reg;
    case (idx_reg)
      2'd0:    hdr_byte = di_reg;
      2'd1:    hdr_byte = wc_reg[7:0];
      2'd2:    hdr_byte = wc_reg[15:8];
      default: hdr_byte = ecc_q_reg;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    pld_ready  = 1'b0;
    ecc_en     = 1'b0;
    ecc_data   = 24'h000000;
    tx_valid   = 1'b0;
    tx_data    = 8'h00;
    tx_last    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          state_next = ST_ECC_REQ;
        end
      end
      ST_ECC_REQ: begin
        ecc_en     = 1'b1;
        ecc_data   = {wc_reg, di_reg};
        state_next = ST_ECC_WAIT;
      end
      ST_ECC_WAIT: begin
        state_next = ST_HDR;
      end
      ST_HDR: begin
        tx_valid = 1'b1;
        tx_data  = hdr_byte;
        tx_last  = (idx_reg == 2'd3) && !long_reg;
        if (tx_ready && (idx_reg == 2'd3)) begin
          if (!long_reg) begin
            state_next = ST_IDLE;
          end else if (cnt_reg == '0) begin
            state_next = ST_CRC;
          end else begin
            state_next = ST_PLD;
          end
        end
      end
      ST_PLD: begin
        tx_valid  = pld_valid;
        tx_data   = pld_data;
        pld_ready = tx_ready;
        if (pld_valid && tx_ready && (cnt_reg == WC_W'(1))) begin
          state_next = ST_CRC;
        end
      end
      ST_CRC: begin
        tx_valid = 1'b1;
        tx_data  = idx_reg[0] ? crc_val[15:8] : crc_val[7:0];
        tx_last  = idx_reg[0];
        if (tx_ready && idx_reg[0]) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      long_reg  <= 1'b0;
      di_reg    <= 8'h00;
      wc_reg    <= 16'h0000;
      cnt_reg   <= '0;
      idx_reg   <= 2'd0;
      ecc_q_reg <= 8'h00;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        long_reg <= cmd_long;
        di_reg   <= {cmd_vc, cmd_dt};
        wc_reg   <= cmd_wc;
        cnt_reg  <= WC_W'(cmd_wc);
      end else if ((state_reg == ST_PLD) && tx_fire) begin
        cnt_reg <= cnt_reg - WC_W'(1);
      end
      if (state_reg == ST_ECC_WAIT) begin
        ecc_q_reg <= ecc_code;
      end
      // Byte index restarts on every state change, so HDR and CRC both count from 0.
      if (state_next != state_reg) begin
        idx_reg <= 2'd0;
      end else if (tx_fire) begin
        idx_reg <= idx_reg + 2'd1;
      end
    end
  end

  dsi_crc16 u_crc (
    .clk  (clk),
    .rst  (rst),
    .init (accept),
    .en   (crc_en),
    .din  (pld_data),
    .crc  (crc_val)
  );

endmodule

// File: tb/tb_dsi_pkt_builder.sv
// Randomized self-checking bench for dsi_pkt_builder with a behavioural ECC
// stage and a packet-level reference model (header, ECC, payload, CRC).
module tb_dsi_pkt_builder;
  import dsi_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_long;
  logic [1:0]  cmd_vc;
  logic [5:0]  cmd_dt;
  logic [15:0] cmd_wc;
  logic        pld_valid;
  logic        pld_ready;
  logic [7:0]  pld_data;
  logic        ecc_en;
  logic [23:0] ecc_data;
  logic [7:0]  ecc_code;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  tx_data;
  logic        tx_last;

  int          vec_cnt = 0;
  int          err_cnt = 0;
  int          pkt_cnt = 0;
  bit          expect_ready = 1'b0;
  logic [7:0]  last_b = 8'h00;
  logic [7:0]  prev_b = 8'h00;
  logic [7:0]  pay_q[$];

  always #5 clk = ~clk;

  dsi_pkt_builder #(.WC_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_long  (cmd_long),
    .cmd_vc    (cmd_vc),
    .cmd_dt    (cmd_dt),
    .cmd_wc    (cmd_wc),
    .pld_valid (pld_valid),
    .pld_ready (pld_ready),
    .pld_data  (pld_data),
    .ecc_en    (ecc_en),
    .ecc_data  (ecc_data),
    .ecc_code  (ecc_code),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_data   (tx_data),
    .tx_last   (tx_last)
  );

  // DSI header ECC: six parity bits over the 24 header bits, P7/P6 zero.
  function automatic logic [7:0] ecc_calc(input logic [23:0] d);
    logic [7:0] p;
    p[0] = ^(d & 24'hF12CB7);
    p[1] = ^(d & 24'hF2555B);
    p[2] = ^(d & 24'h749A6D);
    p[3] = ^(d & 24'hB8E38E);
    p[4] = ^(d & 24'hDF03F0);
    p[5] = ^(d & 24'hEFFC00);
    p[6] = 1'b0;
    p[7] = 1'b0;
    return p;
  endfunction

  // External ECC stage: result registered one cycle after the request.
  always @(posedge clk) begin
    if (rst) begin
      ecc_code <= 8'h00;
    end else if (ecc_en) begin
      ecc_code <= ecc_calc(ecc_data);
    end
  end

  // Reference CRC over pay_q, bit-serial LSB-first.
  function automatic logic [15:0] crc_model();
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    foreach (pay_q[k]) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ pay_q[k][b];
        c  = c >> 1;
        if (fb) c = c ^ 16'h8408;
      end
    end
    return c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic fill_payload(input int n);
    pay_q.delete();
    for (int k = 0; k < n; k++) pay_q.push_back(8'($urandom));
  endtask

  // Drives one packet, checks every emitted byte against the model.
  task automatic run_packet(input bit lng, input logic [1:0] vc, input logic [5:0] dt,
                            input logic [15:0] wc, input int gap_pct, input bit hold,
                            input int rst_at);
    logic [7:0]  exp_q[$];
    logic [7:0]  di;
    logic [15:0] crc;
    logic [7:0]  stall_data;
    logic        stall_last;
    int          n_acc, acc_cyc, ecc_cyc, first_tx, last_cyc, cyc, tx_idx, p_idx;
    bit          done, prev_stall, pld_fired, aborted;

    di = {vc, dt};
    exp_q.push_back(di);
    exp_q.push_back(wc[7:0]);
    exp_q.push_back(wc[15:8]);
    exp_q.push_back(ecc_calc({wc, di}));
    crc = 16'hFFFF;
    if (lng) begin
      foreach (pay_q[k]) exp_q.push_back(pay_q[k]);
      crc = crc_model();
      exp_q.push_back(crc[7:0]);
      exp_q.push_back(crc[15:8]);
    end

    n_acc = 0; acc_cyc = -1; ecc_cyc = -1; first_tx = -1; last_cyc = -1;
    cyc = 0; tx_idx = 0; p_idx = 0;
    done = 1'b0; prev_stall = 1'b0; pld_fired = 1'b0; aborted = 1'b0;
    stall_data = 8'h00; stall_last = 1'b0;

    while (!done && cyc < 4000) begin
      @(negedge clk);
      if (rst_at >= 0 && n_acc > 0 && p_idx == rst_at) begin
        rst = 1'b1; cmd_valid = 1'b0; pld_valid = 1'b0; tx_ready = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_pld_ready", 32'(pld_ready), 32'd0);
        chk("rst_ecc_en", 32'(ecc_en), 32'd0);
        chk("rst_ecc_data", 32'(ecc_data), 32'd0);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_tx_last", 32'(tx_last), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_release_ready", 32'(cmd_ready), 32'd1);
        aborted = 1'b1;
        break;
      end
      cmd_valid = (n_acc == 0) || hold;
      cmd_long  = lng;
      cmd_vc    = vc;
      cmd_dt    = dt;
      cmd_wc    = wc;
      tx_ready  = ($urandom_range(99) >= gap_pct);
      if (lng && p_idx < pay_q.size()) begin
        if (pld_fired || !pld_valid) pld_valid = ($urandom_range(99) >= gap_pct);
        pld_data = pay_q[p_idx];
      end else begin
        pld_valid = 1'b0;
      end
      #1;
      if (expect_ready) begin
        chk("ready_after_last", 32'(cmd_ready), 32'd1);
        expect_ready = 1'b0;
      end
      if (cmd_valid && cmd_ready) begin
        n_acc++;
        if (acc_cyc < 0) acc_cyc = cyc;
      end
      if (ecc_en && ecc_cyc < 0) begin
        ecc_cyc = cyc;
        chk("ecc_data", 32'(ecc_data), 32'({wc, di}));
      end
      if (!lng || wc == 16'h0000) chk("pld_ready_off", 32'(pld_ready), 32'd0);
      if (tx_valid) begin
        if (first_tx < 0) first_tx = cyc;
        if (prev_stall) begin
          chk("stall_data", 32'(tx_data), 32'(stall_data));
          chk("stall_last", 32'(tx_last), 32'(stall_last));
        end
        if (tx_ready) begin
          if (tx_idx >= exp_q.size()) begin
            chk("extra_byte", 32'(tx_idx), 32'(exp_q.size()));
            done = 1'b1;
          end else begin
            chk("byte", 32'(tx_data), 32'(exp_q[tx_idx]));
            chk("last", 32'(tx_last), 32'(tx_idx == exp_q.size() - 1));
            prev_b = last_b;
            last_b = tx_data;
            if (tx_idx == exp_q.size() - 1) begin
              done = 1'b1;
              expect_ready = 1'b1;
              last_cyc = cyc;
            end
          end
          tx_idx++;
        end
      end
      prev_stall = tx_valid && !tx_ready;
      stall_data = tx_data;
      stall_last = tx_last;
      pld_fired  = pld_valid && pld_ready;
      if (pld_fired) p_idx++;
      cyc++;
    end

    if (!aborted) begin
      if (!done) chk("timeout", 32'(tx_idx), 32'(exp_q.size()));
      chk("accepts", 32'(n_acc), 32'd1);
      chk("ecc_latency", 32'(ecc_cyc - acc_cyc), 32'd1);
      chk("tx_latency", 32'(first_tx - acc_cyc), 32'd3);
      if (gap_pct == 0) chk("pkt_cycles", 32'(last_cyc - acc_cyc), lng ? 32'(8 + wc) : 32'd6);
    end
    pkt_cnt++;
    $display("pkt %0d: long=%0d vc=%0d dt=0x%02h wc=0x%04h gap=%0d%% hold=%0d bytes=%0d crc=0x%04h cycles=%0d%s",
             pkt_cnt, lng, vc, dt, wc, gap_pct, hold, tx_idx, crc, cyc,
             aborted ? " reset-abort" : "");
  endtask

  initial begin
    logic [7:0]  ascii[9];
    logic [15:0] wc;
    bit          lng;

    rst = 1'b1; cmd_valid = 1'b1; cmd_long = 1'b0; cmd_vc = 2'd0; cmd_dt = 6'h05;
    cmd_wc = 16'h1234; pld_valid = 1'b0; pld_data = 8'h00; tx_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      chk("reset_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("reset_ecc_en", 32'(ecc_en), 32'd0);
      chk("reset_tx_valid", 32'(tx_valid), 32'd0);
      chk("reset_pld_ready", 32'(pld_ready), 32'd0);
    end
    chk("reset_tx_data", 32'(tx_data), 32'd0);
    chk("reset_ecc_data", 32'(ecc_data), 32'd0);
    chk("reset_tx_last", 32'(tx_last), 32'd0);
    rst = 1'b0;
    cmd_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("release_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("release_ecc_en", 32'(ecc_en), 32'd0);

    // Short write with the ECC stage in the loop.
    pay_q.delete();
    run_packet(1'b0, 2'd0, DCS_SHORT_W0, 16'h0011, 0, 1'b0, -1);
    chk("short_ecc_byte", 32'(last_b), 32'h36);

    // Long write of "123456789".
    ascii = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    pay_q.delete();
    foreach (ascii[k]) pay_q.push_back(ascii[k]);
    run_packet(1'b1, 2'd0, DCS_LONG_W, 16'd9, 0, 1'b0, -1);
    chk("crc_lo_check", 32'(prev_b), 32'h91);
    chk("crc_hi_check", 32'(last_b), 32'h6F);

    // Empty long packet.
    pay_q.delete();
    run_packet(1'b1, 2'd1, DCS_LONG_W, 16'd0, 0, 1'b0, -1);
    chk("wc0_crc_lo", 32'(prev_b), 32'hFF);
    chk("wc0_crc_hi", 32'(last_b), 32'hFF);

    // 64-byte packet, gap-free then with heavy random gaps.
    fill_payload(64);
    run_packet(1'b1, 2'd2, DCS_LONG_W, 16'd64, 0, 1'b0, -1);
    run_packet(1'b1, 2'd2, DCS_LONG_W, 16'd64, 45, 1'b0, -1);

    // Reset while payload byte 5 is on the bus, then a clean short packet.
    fill_payload(20);
    run_packet(1'b1, 2'd3, DCS_LONG_W, 16'd20, 0, 1'b0, 5);
    pay_q.delete();
    run_packet(1'b0, 2'd3, DCS_SHORT_W1, 16'hA55A, 0, 1'b0, -1);

    // cmd_valid held high across back-to-back packets.
    pay_q.delete();
    run_packet(1'b0, 2'd1, DCS_SHORT_W1, 16'h0102, 0, 1'b1, -1);
    fill_payload(7);
    run_packet(1'b1, 2'd2, DCS_LONG_W, 16'd7, 20, 1'b1, -1);
    pay_q.delete();
    run_packet(1'b0, 2'd0, DCS_SHORT_W0, 16'h00FE, 30, 1'b1, -1);
    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
    if (expect_ready) begin
      chk("ready_after_last", 32'(cmd_ready), 32'd1);
      expect_ready = 1'b0;
    end

    // Random mix of packets and gap rates.
    for (int n = 0; n < 10; n++) begin
      lng = 1'($urandom_range(1));
      wc  = lng ? 16'($urandom_range(0, 24)) : 16'($urandom);
      if (lng) fill_payload(int'(wc));
      else pay_q.delete();
      run_packet(lng, 2'($urandom), lng ? DCS_LONG_W : ($urandom_range(1) == 1 ? DCS_SHORT_W0 : DCS_SHORT_W1),
                 wc, int'($urandom_range(0, 50)), 1'b0, -1);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
    if (expect_ready) begin
      chk("ready_after_last", 32'(cmd_ready), 32'd1);
      expect_ready = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
